// File: rtl/activation_pkg.sv
// Shared types and helpers for the CNN activation stage: mode encoding and
// a sign-bit population count used by the negative-sample statistics.
package activation_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLAMP  = 2'd3
  } act_mode_e;

  // Widest pixel the sign counter supports; callers zero-fill unused bits.
  localparam int MAX_CHANNELS    = 64;
  localparam int NEG_COUNT_WIDTH = 7;

  function automatic logic [NEG_COUNT_WIDTH-1:0] count_neg(
    input logic [MAX_CHANNELS-1:0] sign_bits
  );
    logic [NEG_COUNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      n += NEG_COUNT_WIDTH'(sign_bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/activation_lane.sv
// Combinational single-channel activation: bypass, ReLU, leaky ReLU
// (arithmetic shift, floor rounding) or ReLU clamped to [0, clamp].
module activation_lane
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  act_mode_e                    mode,
  input  logic signed [DATA_WIDTH-1:0] clamp,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH-1:0] ceiling;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    y       = x;
    ceiling = clamp[DATA_WIDTH-1] ? '0 : clamp;
    unique case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU:   y = x[DATA_WIDTH-1] ? '0 : x;
      ACT_LEAKY:  y = x[DATA_WIDTH-1] ? (x >>> LEAK_SHIFT) : x;
      ACT_CLAMP:  y = x[DATA_WIDTH-1] ? '0 : ((x > ceiling) ? ceiling : x);
      default:    y = x;
    endcase
  end

endmodule

// File: rtl/activation_unit.sv
// Two-stage handshaked activation stage: S1 captures a beat and its config,
// S2 holds the activated result; also counts negative samples per frame.
module activation_unit
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CHANNELS    = 9,
  parameter int LEAK_SHIFT  = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  input  logic [1:0]                     cfg_mode,
  input  logic [DATA_WIDTH-1:0]          cfg_clamp,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [COUNT_WIDTH-1:0]         stat_neg_count,
  output logic                           stat_valid
);

  localparam int SUM_WIDTH = COUNT_WIDTH + 1;

  logic                           en;
  logic                           s1_valid;
  logic                           s1_last;
  logic [CHANNELS*DATA_WIDTH-1:0] s1_data;
  act_mode_e                      s1_mode;
  logic [DATA_WIDTH-1:0]          s1_clamp;
  logic [CHANNELS*DATA_WIDTH-1:0] lane_out;

  logic [MAX_CHANNELS-1:0]        s1_signs;
  logic [NEG_COUNT_WIDTH-1:0]     beat_neg;
  logic [COUNT_WIDTH-1:0]         run_count;
  logic [SUM_WIDTH-1:0]           sum_wide;
  logic [COUNT_WIDTH-1:0]         sum_sat;

  // The whole pipeline advances together; a stalled output freezes S1 too.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    activation_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .x    (s1_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .mode (s1_mode),
      .clamp(s1_clamp),
      .y    (lane_out[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: data registers are reset too, since out_data must read 0 after reset.
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= ACT_BYPASS;
      s1_clamp  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_data  <= in_data;
        s1_last  <= in_last;
        s1_mode  <= act_mode_e'(cfg_mode);
        s1_clamp <= cfg_clamp;
      end
      if (s1_valid) begin
        out_data <= lane_out;
        out_last <= s1_last;
      end
    end
  end

  always_comb begin
    s1_signs = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s1_signs[i] = s1_data[i*DATA_WIDTH + DATA_WIDTH - 1];
    end
  end

  assign beat_neg = count_neg(s1_signs);
  assign sum_wide = {1'b0, run_count} + SUM_WIDTH'(beat_neg);
  assign sum_sat  = sum_wide[COUNT_WIDTH] ? '1 : sum_wide[COUNT_WIDTH-1:0];

  // Counts beats as they leave S1, so stalled beats are counted exactly once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_count      <= '0;
      stat_neg_count <= '0;
      stat_valid     <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      if (en && s1_valid) begin
        if (s1_last) begin
          stat_neg_count <= sum_sat;
          stat_valid     <= 1'b1;
          run_count      <= '0;
        end else begin
          run_count <= sum_sat;
        end
      end
    end
  end

endmodule
